mmio_bridge: RTL

Parametrised, multi-cycle memory-mapped bus bridge between the CPU data port and the data memory plus NUM_DEV I/O peripherals. It is the successor to the single-cycle combinational bridge. It decodes an I/O page and per-device address windows, and runs a request/acknowledge handshake with per-target wait states. It also reports an error for unmapped addresses and unresponsive targets. It sits between myCPU's bus port and DRAM / LEDs / switches / buttons / digital LEDs in miniRV_SoC.

---
 rtl/mmio_bridge.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mmio_bridge.sv
// mmio_bridge: multi-cycle CPU data-port bridge to data memory and NUM_DEV I/O devices.
//
// An access presented in IDLE is latched and decoded. An address outside the I/O page goes to
// memory. Inside the I/O page, each device is matched against its base/mask window, and the
// lowest matching index wins. If no device matches, the access goes straight to a response
// with an error. The target strobe stays high until the target's ready arrives or the optional
// wait-state timeout expires. cpu_ack then pulses for one cycle, together with cpu_err and
// cpu_rdata, which are both registered.
//
// Ports:
//   cpu_clk, cpu_rst             clock, synchronous active-high reset
//   cpu_req/addr/wen/wdata       CPU request (held until ack)
//   cpu_ack/rdata/err            completion pulse, read data (held), error flag
//   mem_req/addr/wen/wdata       memory strobe and latched access fields
//   mem_rdata, mem_ready         memory return path
//   dev_sel/addr/wen/wdata       one-hot device select and latched access fields
//   dev_rdata, dev_ready         packed per-device return path (device 0 in LSBs)

module mmio_bridge #(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          NUM_DEV  = 4,
    parameter logic [ADDR_W-13:0]   IO_PAGE  = 20'hFFFFF,
    parameter logic [NUM_DEV*12-1:0] DEV_BASE = {12'h078, 12'h070, 12'h060, 12'h000},
    parameter logic [NUM_DEV*12-1:0] DEV_MASK = {12'hFFC, 12'hFFC, 12'hFFC, 12'hFE0},
    parameter int unsigned          TIMEOUT  = 16,
    parameter logic [DATA_W-1:0]    ERR_DATA = 32'hDEADBEEF
) (
    input  logic                      cpu_clk,
    input  logic                      cpu_rst,
    input  logic                      cpu_req,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic                      cpu_wen,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic                      cpu_ack,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_err,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_wen,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ready,
    output logic [NUM_DEV-1:0]        dev_sel,
    output logic [11:0]               dev_addr,
    output logic                      dev_wen,
    output logic [DATA_W-1:0]         dev_wdata,
    input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
    input  logic [NUM_DEV-1:0]        dev_ready
);

    // With TIMEOUT=0 the counter is unused, but it keeps a legal one-bit width.
    localparam int unsigned        CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    typedef enum logic [1:0] {StIdle, StMem, StDev, StResp} state_e;

    state_e              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_addr, w_addr_next;
    logic                r_wen, w_wen_next;
    logic [DATA_W-1:0]   r_wdata, w_wdata_next;
    logic [NUM_DEV-1:0]  r_sel, w_sel_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic [DATA_W-1:0]   r_rdata, w_rdata_next;
    logic                r_err, w_err_next;

    logic                w_io_page;
    logic [NUM_DEV-1:0]  w_hit_sel;
    logic                w_dev_ready;
    logic [DATA_W-1:0]   w_dev_rdata;
    logic                w_timeout;

    // Address decode on the live request. The scan runs from the highest index downwards,
    // so the lowest matching device is the last one written and therefore wins.
    always_comb begin
        w_io_page = (cpu_addr[ADDR_W-1:12] == IO_PAGE);
        w_hit_sel = '0;
        for (int i = int'(NUM_DEV) - 1; i >= 0; i--) begin
            if ((cpu_addr[11:0] & DEV_MASK[i*12 +: 12]) == DEV_BASE[i*12 +: 12]) begin
                w_hit_sel    = '0;
                w_hit_sel[i] = 1'b1;
            end
        end
    end

    // Return path from the latched device only; other devices are ignored.
    always_comb begin
        w_dev_ready = |(dev_ready & r_sel);
        w_dev_rdata = '0;
        for (int i = 0; i < int'(NUM_DEV); i++) begin
            if (r_sel[i]) begin
                w_dev_rdata = w_dev_rdata | dev_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_wen_next   = r_wen;
        w_wdata_next = r_wdata;
        w_sel_next   = r_sel;
        w_cnt_next   = r_cnt;
        w_rdata_next = r_rdata;
        w_err_next   = r_err;

        unique case (r_state)
            StIdle: begin
                w_cnt_next = '0;
                if (cpu_req) begin
                    w_addr_next  = cpu_addr;
                    w_wen_next   = cpu_wen;
                    w_wdata_next = cpu_wdata;
                    if (!w_io_page) begin
                        w_sel_next   = '0;
                        w_state_next = StMem;
                    end else if (|w_hit_sel) begin
                        w_sel_next   = w_hit_sel;
                        w_state_next = StDev;
                    end else begin
                        w_sel_next   = '0;
                        w_err_next   = 1'b1;
                        w_rdata_next = ERR_DATA;
                        w_state_next = StResp;
                    end
                end
            end
            StMem: begin
                // Ready takes precedence over a timeout that expires in the same cycle.
                if (mem_ready) begin
                    w_rdata_next = r_wen ? '0 : mem_rdata;
                    w_err_next   = 1'b0;
                    w_state_next = StResp;
                end else if (w_timeout) begin
                    w_rdata_next = ERR_DATA;
                    w_err_next   = 1'b1;
                    w_state_next = StResp;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            StDev: begin
                if (w_dev_ready) begin
                    w_rdata_next = r_wen ? '0 : w_dev_rdata;
                    w_err_next   = 1'b0;
                    w_state_next = StResp;
                end else if (w_timeout) begin
                    w_rdata_next = ERR_DATA;
                    w_err_next   = 1'b1;
                    w_state_next = StResp;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            StResp: begin
                w_sel_next   = '0;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_wen   <= w_wen_next;
            r_wdata <= w_wdata_next;
            r_sel   <= w_sel_next;
            r_cnt   <= w_cnt_next;
            r_rdata <= w_rdata_next;
            r_err   <= w_err_next;
        end
    end

    // Strobes are decoded from the state register, so they are glitch-free and drop on reset.
    assign cpu_ack   = (r_state == StResp);
    assign cpu_rdata = r_rdata;
    assign cpu_err   = r_err;
    assign mem_req   = (r_state == StMem);
    assign mem_addr  = r_addr;
    assign mem_wen   = (r_state == StMem) & r_wen;
    assign mem_wdata = r_wdata;
    assign dev_sel   = (r_state == StDev) ? r_sel : '0;
    assign dev_addr  = r_addr[11:0];
    assign dev_wen   = (r_state == StDev) & r_wen;
    assign dev_wdata = r_wdata;

endmodule
